// File: rtl/sysx_slave_port.sv
// sysX bus slave endpoint: oversamples bus clock/select, shifts 32-bit words over 8-bit lanes.
// Latency: bus edges act SYNC_STAGES+1 iClock cycles after they occur; RX word publishes on the Store edge.
// Backpressure: TX holding register empties on each frame Load; RX word held until iRxReady, extra words dropped (overrun).
module sysx_slave_port #(
  parameter logic [1:0]  SELECT_ID     = 2'h1,
  parameter logic [31:0] UNDERRUN_WORD = 32'hFFFFFFFF,
  parameter int          SYNC_STAGES   = 2
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iBusClock,
  input  logic [1:0]  iBusSelect,
  input  logic [7:0]  iBusMOSI,
  output logic [7:0]  oBusMISO,
  output logic        oBusMISOEnable,
  output logic        oBusInterrupt,
  input  logic        iIrqRequest,
  input  logic [31:0] iTxData,
  input  logic        iTxValid,
  output logic        oTxReady,
  output logic [31:0] oRxData,
  output logic        oRxValid,
  input  logic        iRxReady,
  output logic        oUnderrun,
  output logic        oOverrun,
  output logic        oAbort,
  input  logic        iClearFlags
);

  // Synchroniser chains; fill_q marks when the chains hold real bus samples after reset.
  logic [SYNC_STAGES-1:0]       clk_sync_q, fill_q;
  logic [SYNC_STAGES-1:0][1:0]  sel_sync_q;
  logic                         clk_prev_q;

  logic        sel, fe_act;
  logic [2:0]  phase_q, phase_d;
  logic        armed_q, armed_d;
  logic [31:0] hold_q, hold_d, shift_q, shift_d, rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic        hold_full_q, hold_full_d, rx_valid_q, rx_valid_d;
  logic [7:0]  miso_q, miso_d;
  logic        en_q, irq_q, unr_q, unr_d, ovr_q, ovr_d, abort_q;
  logic        unr_set, ovr_set;

  // Bus clock idles high, so the clock chain resets high to avoid a phantom falling edge.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      clk_sync_q <= '1;
      sel_sync_q <= '0;
      fill_q     <= '0;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], iBusClock};
      sel_sync_q <= {sel_sync_q[SYNC_STAGES-2:0], iBusSelect};
      fill_q     <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign sel    = (sel_sync_q[SYNC_STAGES-1] == SELECT_ID);
  assign fe_act = sel & clk_prev_q & ~clk_sync_q[SYNC_STAGES-1] & armed_q;

  // Next-state for frame phase, TX/RX data paths and sticky flags.
  always_comb begin
    phase_d     = phase_q;
    armed_d     = armed_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    miso_d      = miso_q;
    unr_set     = 1'b0;
    ovr_set     = 1'b0;

    // A deselect is only trusted once the chain has filled, so a reset released
    // mid-frame keeps ignoring edges until the master really lets go.
    if (!sel && fill_q[SYNC_STAGES-1]) armed_d = 1'b1;

    if (iTxValid && !hold_full_q) begin
      hold_d      = iTxData;
      hold_full_d = 1'b1;
    end

    if (rx_valid_q && iRxReady) rx_valid_d = 1'b0;

    if (!sel) begin
      phase_d = 3'd0;
      miso_d  = 8'hFF;
    end else if (fe_act) begin
      phase_d = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
      case (phase_q)
        3'd0: begin
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            miso_d      = hold_q[7:0];
          end else begin
            shift_d = UNDERRUN_WORD;
            unr_set = 1'b1;
            miso_d  = UNDERRUN_WORD[7:0];
          end
        end
        3'd1: begin rx_shift_d[7:0]   = iBusMOSI; miso_d = shift_q[15:8];  end
        3'd2: begin rx_shift_d[15:8]  = iBusMOSI; miso_d = shift_q[23:16]; end
        3'd3: begin rx_shift_d[23:16] = iBusMOSI; miso_d = shift_q[31:24]; end
        3'd4: begin rx_shift_d[31:24] = iBusMOSI; miso_d = 8'hFF;          end
        default: begin
          if (!rx_valid_q || iRxReady) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
          end else begin
            ovr_set = 1'b1;
          end
        end
      endcase
    end

    unr_d = unr_set | (unr_q & ~iClearFlags);
    ovr_d = ovr_set | (ovr_q & ~iClearFlags);
  end

  // State registers; abort fires on the first deselected cycle of an unfinished frame.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      phase_q     <= 3'd0;
      armed_q     <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      miso_q      <= 8'hFF;
      en_q        <= 1'b0;
      irq_q       <= 1'b0;
      unr_q       <= 1'b0;
      ovr_q       <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      armed_q     <= armed_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      miso_q      <= miso_d;
      en_q        <= sel;
      irq_q       <= iIrqRequest;
      unr_q       <= unr_d;
      ovr_q       <= ovr_d;
      abort_q     <= ~sel & (phase_q != 3'd0);
    end
  end

  assign oBusMISO       = en_q ? miso_q : 8'hFF;
  assign oBusMISOEnable = en_q;
  assign oBusInterrupt  = irq_q;
  assign oTxReady       = ~hold_full_q;
  assign oRxData        = rx_data_q;
  assign oRxValid       = rx_valid_q;
  assign oUnderrun      = unr_q;
  assign oOverrun       = ovr_q;
  assign oAbort         = abort_q;

endmodule

// File: tb/tb_sysx_slave_port.sv
// Bench for sysx_slave_port: drives a sysX master model and scores RX words through a queue.
module tb_sysx_slave_port;
  localparam int         HALF = 8;
  localparam int         SYNC = 2;
  localparam logic [1:0] ID   = 2'h1;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_clk, rx_ready, tx_valid, irq_req, clr;
  logic [1:0]  bus_sel;
  logic [7:0]  bus_mosi, miso;
  logic [31:0] tx_data, rx_data;
  logic        miso_en, irq_o, tx_ready, rx_valid, unr, ovr, abort_o;

  int checks = 0;
  int failures = 0;
  int abort_cycles = 0;
  logic [31:0] rx_q [$];

  always #5 clk = ~clk;

  sysx_slave_port #(.SELECT_ID(ID), .UNDERRUN_WORD(32'hFFFFFFFF), .SYNC_STAGES(SYNC)) dut (
    .iClock(clk), .iReset(rst), .iBusClock(bus_clk), .iBusSelect(bus_sel),
    .iBusMOSI(bus_mosi), .oBusMISO(miso), .oBusMISOEnable(miso_en),
    .oBusInterrupt(irq_o), .iIrqRequest(irq_req), .iTxData(tx_data),
    .iTxValid(tx_valid), .oTxReady(tx_ready), .oRxData(rx_data),
    .oRxValid(rx_valid), .iRxReady(rx_ready), .oUnderrun(unr),
    .oOverrun(ovr), .oAbort(abort_o), .iClearFlags(clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // RX scoreboard: every local handshake must match the oldest expected word.
  always begin
    logic [31:0] exp;
    @(negedge clk);
    #1;
    if (abort_o) abort_cycles++;
    if (!rst && rx_valid && rx_ready) begin
      if (rx_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rx_unexpected actual=%h required=none", rx_data);
      end else begin
        exp = rx_q.pop_front();
        chk("rx_word", rx_data, exp);
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_miso"},  32'(miso),     32'h000000FF);
    chk({tag, "_en"},    32'(miso_en),  32'd0);
    chk({tag, "_irq"},   32'(irq_o),    32'd0);
    chk({tag, "_txrdy"}, 32'(tx_ready), 32'd1);
    chk({tag, "_rxvld"}, 32'(rx_valid), 32'd0);
    chk({tag, "_rxdat"}, rx_data,       32'd0);
    chk({tag, "_unr"},   32'(unr),      32'd0);
    chk({tag, "_ovr"},   32'(ovr),      32'd0);
    chk({tag, "_abort"}, 32'(abort_o),  32'd0);
  endtask

  task automatic push_tx(input logic [31:0] w);
    int n = 0;
    while (!tx_ready && n < 200) begin @(negedge clk); n++; end
    if (!tx_ready) chk("tx_ready_timeout", 32'(tx_ready), 32'd1);
    tx_data  = w;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic clear_flags();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  // Master side of bus periods p_first..p_last; MISO sampled just before each falling edge.
  task automatic bus_word(input logic [31:0] mosi, input logic [31:0] exp_miso,
                          input int p_first, input int p_last,
                          input bit ready_at_store, input string name);
    logic [31:0] got;
    got = 32'hFFFFFFFF;
    for (int p = p_first; p <= p_last; p++) begin
      if (p >= 1 && p <= 4) bus_mosi = mosi[8*(p-1) +: 8];
      else                  bus_mosi = 8'hEE;
      repeat (HALF) @(negedge clk);
      if (p >= 1 && p <= 4) got[8*(p-1) +: 8] = miso;
      bus_clk = 1'b0;
      if (p == 5 && ready_at_store) begin
        repeat (SYNC) @(negedge clk);
        rx_ready = 1'b1;
        repeat (HALF - SYNC) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      bus_clk = 1'b1;
    end
    chk(name, got, exp_miso);
  endtask

  task automatic frame(input logic [1:0] sel, input logic [31:0] mosi, input logic [31:0] exp_miso,
                       input bit push_rx, input bit ready_at_store, input string name);
    if (push_rx) rx_q.push_back(mosi);
    bus_sel = sel;
    repeat (HALF) @(negedge clk);
    bus_word(mosi, exp_miso, 0, 5, ready_at_store, name);
    repeat (HALF) @(negedge clk);
    bus_sel = 2'h0;
    repeat (2*HALF) @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] mosi;
    bit          load_tx;
    logic [31:0] tx;
    logic [31:0] exp_miso;
    bit          exp_unr;
  } vec_t;

  initial begin
    vec_t vecs [4];
    logic [31:0] blk_m [3];
    logic [31:0] blk_t [3];
    int a0;

    vecs[0] = '{32'h12345678, 1'b1, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
    vecs[1] = '{32'h00FF00FF, 1'b1, 32'h01020304, 32'h01020304, 1'b0};
    vecs[2] = '{32'hFFFFFFFF, 1'b0, 32'h0,        32'hFFFFFFFF, 1'b1};
    vecs[3] = '{32'hA5A55A5A, 1'b1, 32'h80000001, 32'h80000001, 1'b0};
    blk_m = '{32'h11112222, 32'h33334444, 32'h55556666};
    blk_t = '{32'hDEADBEEF, 32'h0BADF00D, 32'hFEEDFACE};

    rst = 1'b1; bus_clk = 1'b1; bus_sel = 2'h0; bus_mosi = 8'h00;
    rx_ready = 1'b1; tx_valid = 1'b0; tx_data = '0; irq_req = 1'b0; clr = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    irq_req = 1'b1;
    @(negedge clk);
    chk("irq_set", 32'(irq_o), 32'd1);
    irq_req = 1'b0;
    @(negedge clk);
    chk("irq_clr", 32'(irq_o), 32'd0);

    // Single-word frames from the vector table.
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].load_tx) push_tx(vecs[i].tx);
      frame(ID, vecs[i].mosi, vecs[i].exp_miso, 1'b1, 1'b0, "vec_miso");
      chk("vec_underrun", 32'(unr), 32'(vecs[i].exp_unr));
      chk("vec_txready", 32'(tx_ready), 32'd1);
      clear_flags();
      chk("vec_unr_cleared", 32'(unr), 32'd0);
    end

    // Block of three words with select held; holding refilled each frame.
    push_tx(blk_t[0]);
    for (int i = 0; i < 3; i++) rx_q.push_back(blk_m[i]);
    bus_sel = ID;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) push_tx(blk_t[i]);
      bus_word(blk_m[i], blk_t[i], 0, 5, 1'b0, "blk_miso");
    end
    repeat (HALF) @(negedge clk);
    bus_sel = 2'h0;
    repeat (2*HALF) @(negedge clk);
    chk("blk_unr", 32'(unr), 32'd0);
    chk("blk_ovr", 32'(ovr), 32'd0);

    // Overrun: second word dropped while first is still held.
    rx_ready = 1'b0;
    push_tx(32'h0A0B0C0D);
    frame(ID, 32'hAAAA0001, 32'h0A0B0C0D, 1'b1, 1'b0, "ovr_a_miso");
    push_tx(32'h1A1B1C1D);
    frame(ID, 32'hBBBB0002, 32'h1A1B1C1D, 1'b0, 1'b0, "ovr_b_miso");
    chk("ovr_valid", 32'(rx_valid), 32'd1);
    chk("ovr_kept",  rx_data, 32'hAAAA0001);
    chk("ovr_flag",  32'(ovr), 32'd1);
    rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("ovr_drained", 32'(rx_valid), 32'd0);
    clear_flags();
    chk("ovr_cleared", 32'(ovr), 32'd0);

    // Ready raised exactly on the Store cycle: publish and consume together.
    rx_ready = 1'b0;
    push_tx(32'h2A2B2C2D);
    frame(ID, 32'hCCCC0003, 32'h2A2B2C2D, 1'b1, 1'b0, "same_c_miso");
    push_tx(32'h3A3B3C3D);
    frame(ID, 32'hDDDD0004, 32'h3A3B3C3D, 1'b1, 1'b1, "same_d_miso");
    chk("same_no_ovr", 32'(ovr), 32'd0);

    // Select dropped after B1: one abort pulse, nothing published.
    push_tx(32'h89ABCDEF);
    a0 = abort_cycles;
    bus_sel = ID;
    repeat (HALF) @(negedge clk);
    bus_word(32'h77778888, 32'hFFFFCDEF, 0, 2, 1'b0, "abort_miso");
    bus_sel = 2'h0;
    repeat (2*HALF) @(negedge clk);
    chk("abort_pulse", 32'(abort_cycles - a0), 32'd1);
    chk("abort_no_rx", 32'(rx_valid), 32'd0);
    chk("abort_tx_sent", 32'(tx_ready), 32'd1);
    push_tx(32'h44556677);
    frame(ID, 32'h9876FEDC, 32'h44556677, 1'b1, 1'b0, "post_abort_miso");

    // Reset pulsed mid-frame: remainder of that frame ignored.
    push_tx(32'h13579BDF);
    bus_sel = ID;
    repeat (HALF) @(negedge clk);
    bus_word(32'h5555AAAA, 32'hFFFF9BDF, 0, 2, 1'b0, "rstmid_pre_miso");
    push_tx(32'h2468ACE0);
    chk("rstmid_hold_full", 32'(tx_ready), 32'd0);
    a0 = abort_cycles;
    rst = 1'b1;
    @(negedge clk);
    chk_reset("rstmid");
    rst = 1'b0;
    bus_word(32'h5555AAAA, 32'hFFFFFFFF, 3, 5, 1'b0, "rstmid_post_miso");
    repeat (HALF) @(negedge clk);
    bus_sel = 2'h0;
    repeat (2*HALF) @(negedge clk);
    chk("rstmid_no_rx", 32'(rx_valid), 32'd0);
    chk("rstmid_no_abort", 32'(abort_cycles - a0), 32'd0);
    chk("rstmid_no_unr", 32'(unr), 32'd0);
    push_tx(32'hC0FFEE11);
    frame(ID, 32'h0F1E2D3C, 32'hC0FFEE11, 1'b1, 1'b0, "rstmid_next_miso");

    // Another peripheral's select: no enable, no RX, holding untouched.
    push_tx(32'h600DCAFE);
    bus_sel = 2'h2;
    repeat (HALF) @(negedge clk);
    bus_word(32'h87654321, 32'hFFFFFFFF, 0, 5, 1'b0, "other_miso");
    chk("other_en", 32'(miso_en), 32'd0);
    repeat (HALF) @(negedge clk);
    bus_sel = 2'h0;
    repeat (2*HALF) @(negedge clk);
    chk("other_hold_kept", 32'(tx_ready), 32'd0);
    frame(ID, 32'h31415926, 32'h600DCAFE, 1'b1, 1'b0, "other_next_miso");
    chk("other_unr", 32'(unr), 32'd0);

    for (int i = 0; i < 200 && rx_q.size() != 0; i++) @(negedge clk);
    chk("rx_queue_empty", 32'(rx_q.size()), 32'd0);
    chk("abort_total", 32'(abort_cycles), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
